retire_lockstep_checker: RTL and testbench

Synthesizable lockstep comparator that checks a core's retirement stream against a second retirement stream, either from a reference core or a replayed golden trace, in hardware. Each stream is buffered in its own FIFO of DEPTH entries, and heads are compared in order. Mismatches, first-failure context and event counts are captured for the debug port. The block sits beside `core`, fed by its post-execution debug strobe and register write-back, and lets long runs be checked on FPGA without the C model.

---
 rtl/retire_lockstep_checker.sv | 136 +++++++++++++
 tb/tb_retire_lockstep_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_lockstep_checker.sv
// Lockstep checker for two retirement streams: each stream is queued in its own FIFO,
// the heads are compared pairwise, and the first-failure context and event counts are captured.
module retire_lockstep_checker #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RIDX        = 5,
  parameter int unsigned DEPTH       = 8,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            a_valid,
  input  logic [XLEN-1:0] a_pc,
  input  logic            a_we,
  input  logic [RIDX-1:0] a_rd,
  input  logic [XLEN-1:0] a_wdata,
  input  logic            b_valid,
  input  logic [XLEN-1:0] b_pc,
  input  logic            b_we,
  input  logic [RIDX-1:0] b_rd,
  input  logic [XLEN-1:0] b_wdata,
  output logic            err,
  output logic            overflow,
  output logic            halted,
  output logic [XLEN-1:0] fail_a_pc,
  output logic [XLEN-1:0] fail_b_pc,
  output logic [XLEN-1:0] fail_a_wdata,
  output logic [XLEN-1:0] fail_b_wdata,
  output logic [RIDX-1:0] fail_rd,
  output logic [31:0]     cmp_count,
  output logic [15:0]     mis_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            we;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] wdata;
  } rec_t;

  // Writes to x0 are not architectural, and rd/wdata mean nothing without a write.
  function automatic rec_t normalise(input logic [XLEN-1:0] pc, input logic we,
                                     input logic [RIDX-1:0] rd, input logic [XLEN-1:0] wdata);
    rec_t r;
    r.pc    = pc;
    r.we    = we && (rd != '0);
    r.rd    = r.we ? rd : '0;
    r.wdata = r.we ? wdata : '0;
    return r;
  endfunction

  rec_t            a_mem [DEPTH];
  rec_t            b_mem [DEPTH];
  logic [PW-1:0]   a_wp, a_rp, b_wp, b_rp;

  logic            flush_c;
  logic            a_empty_c, b_empty_c, a_full_c, b_full_c;
  logic            do_cmp_c, match_c;
  logic            a_push_c, b_push_c, a_drop_c, b_drop_c;
  rec_t            a_rec_c, b_rec_c, a_head_c, b_head_c;

  // Full/empty come from the extra wrap bit of each pointer pair.
  always_comb begin
    flush_c   = rst || clear;
    a_empty_c = (a_wp == a_rp);
    b_empty_c = (b_wp == b_rp);
    a_full_c  = (a_wp[AW] != a_rp[AW]) && (a_wp[AW-1:0] == a_rp[AW-1:0]);
    b_full_c  = (b_wp[AW] != b_rp[AW]) && (b_wp[AW-1:0] == b_rp[AW-1:0]);
    a_head_c  = a_mem[a_rp[AW-1:0]];
    b_head_c  = b_mem[b_rp[AW-1:0]];
    a_rec_c   = normalise(a_pc, a_we, a_rd, a_wdata);
    b_rec_c   = normalise(b_pc, b_we, b_rd, b_wdata);
    do_cmp_c  = !a_empty_c && !b_empty_c && !halted;
    match_c   = (a_head_c == b_head_c);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    a_push_c  = a_valid && !halted && !flush_c && (!a_full_c || do_cmp_c);
    b_push_c  = b_valid && !halted && !flush_c && (!b_full_c || do_cmp_c);
    a_drop_c  = a_valid && !halted && a_full_c && !do_cmp_c;
    b_drop_c  = b_valid && !halted && b_full_c && !do_cmp_c;
  end

  // Record storage; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (a_push_c) a_mem[a_wp[AW-1:0]] <= a_rec_c;
    if (b_push_c) b_mem[b_wp[AW-1:0]] <= b_rec_c;
  end

  // Pointers, flags, counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      a_wp         <= '0;
      a_rp         <= '0;
      b_wp         <= '0;
      b_rp         <= '0;
      err          <= 1'b0;
      overflow     <= 1'b0;
      halted       <= 1'b0;
      fail_a_pc    <= '0;
      fail_b_pc    <= '0;
      fail_a_wdata <= '0;
      fail_b_wdata <= '0;
      fail_rd      <= '0;
      cmp_count    <= '0;
      mis_count    <= '0;
    end else begin
      if (a_push_c) a_wp <= a_wp + PW'(1);
      if (b_push_c) b_wp <= b_wp + PW'(1);
      if (a_drop_c || b_drop_c) begin
        overflow <= 1'b1;
        err      <= 1'b1;
      end
      if (do_cmp_c) begin
        a_rp      <= a_rp + PW'(1);
        b_rp      <= b_rp + PW'(1);
        cmp_count <= cmp_count + 32'd1;
        if (!match_c) begin
          err <= 1'b1;
          if (mis_count != 16'hFFFF) mis_count <= mis_count + 16'd1;
          // mis_count saturates and never returns to zero, so zero marks "no failure yet".
          if (mis_count == 16'd0) begin
            fail_a_pc    <= a_head_c.pc;
            fail_b_pc    <= b_head_c.pc;
            fail_a_wdata <= a_head_c.wdata;
            fail_b_wdata <= b_head_c.wdata;
            fail_rd      <= a_head_c.rd;
          end
          if (STOP_ON_ERR) halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_retire_lockstep_checker.sv
// Directed bench for retire_lockstep_checker: a freezing instance and a counting instance
// share the same two input streams.
module tb_retire_lockstep_checker;

  logic        clk;
  logic        rst, clear;
  logic        a_valid, a_we, b_valid, b_we;
  logic [31:0] a_pc, a_wdata, b_pc, b_wdata;
  logic [4:0]  a_rd, b_rd;

  logic        s_err, s_overflow, s_halted;
  logic [31:0] s_fail_a_pc, s_fail_b_pc, s_fail_a_wdata, s_fail_b_wdata, s_cmp_count;
  logic [4:0]  s_fail_rd;
  logic [15:0] s_mis_count;

  logic        n_err, n_overflow, n_halted;
  logic [31:0] n_fail_a_pc, n_fail_b_pc, n_fail_a_wdata, n_fail_b_wdata, n_cmp_count;
  logic [4:0]  n_fail_rd;
  logic [15:0] n_mis_count;

  int n_checks = 0;
  int n_errors = 0;

  retire_lockstep_checker #(.XLEN(32), .RIDX(5), .DEPTH(8), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .a_valid(a_valid), .a_pc(a_pc), .a_we(a_we), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_pc(b_pc), .b_we(b_we), .b_rd(b_rd), .b_wdata(b_wdata),
    .err(s_err), .overflow(s_overflow), .halted(s_halted),
    .fail_a_pc(s_fail_a_pc), .fail_b_pc(s_fail_b_pc),
    .fail_a_wdata(s_fail_a_wdata), .fail_b_wdata(s_fail_b_wdata),
    .fail_rd(s_fail_rd), .cmp_count(s_cmp_count), .mis_count(s_mis_count)
  );

  retire_lockstep_checker #(.XLEN(32), .RIDX(5), .DEPTH(8), .STOP_ON_ERR(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .clear(clear),
    .a_valid(a_valid), .a_pc(a_pc), .a_we(a_we), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_pc(b_pc), .b_we(b_we), .b_rd(b_rd), .b_wdata(b_wdata),
    .err(n_err), .overflow(n_overflow), .halted(n_halted),
    .fail_a_pc(n_fail_a_pc), .fail_b_pc(n_fail_b_pc),
    .fail_a_wdata(n_fail_a_wdata), .fail_b_wdata(n_fail_b_wdata),
    .fail_rd(n_fail_rd), .cmp_count(n_cmp_count), .mis_count(n_mis_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] rd, input logic [31:0] wd);
    a_valid = v; a_pc = pc; a_we = we; a_rd = rd; a_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] rd, input logic [31:0] wd);
    b_valid = v; b_pc = pc; b_we = we; b_rd = rd; b_wdata = wd;
  endtask

  task automatic idle();
    set_a(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_b(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle();
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_err", 64'(s_err), 64'd0);
    check("rst_overflow", 64'(s_overflow), 64'd0);
    check("rst_halted", 64'(s_halted), 64'd0);
    check("rst_cmp", 64'(s_cmp_count), 64'd0);
    check("rst_mis", 64'(s_mis_count), 64'd0);
    check("rst_fail_pc", 64'(s_fail_a_pc), 64'd0);

    // Aligned matching streams
    for (int i = 0; i < 20; i++) begin
      set_a(1'b1, 32'(4 * i), 1'b1, 5'(i % 32), 32'(i));
      set_b(1'b1, 32'(4 * i), 1'b1, 5'(i % 32), 32'(i));
      tick();
    end
    idle();
    check("align_cmp_19", 64'(s_cmp_count), 64'd19);
    tick();
    check("align_cmp", 64'(s_cmp_count), 64'd20);
    check("align_mis", 64'(s_mis_count), 64'd0);
    check("align_err", 64'(s_err), 64'd0);
    check("align_ns_cmp", 64'(n_cmp_count), 64'd20);

    // Skew: B runs DEPTH records behind A (the 8th A record is stored as B's first arrives)
    do_clear();
    check("clr_cmp", 64'(s_cmp_count), 64'd0);
    for (int t = 0; t < 27; t++) begin
      if (t < 20) set_a(1'b1, 32'(4 * t), 1'b1, 5'(t), 32'(t));
      else        set_a(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (t >= 7) set_b(1'b1, 32'(4 * (t - 7)), 1'b1, 5'(t - 7), 32'(t - 7));
      else        set_b(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
    end
    idle();
    tick();
    check("skew_overflow", 64'(s_overflow), 64'd0);
    check("skew_cmp", 64'(s_cmp_count), 64'd20);
    check("skew_err", 64'(s_err), 64'd0);

    // Lag overflow: nine A records with no B records
    do_clear();
    for (int t = 0; t < 9; t++) begin
      set_a(1'b1, 32'(4 * t), 1'b1, 5'(t), 32'(t));
      set_b(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      if (t == 7) check("lag_ovf_before", 64'(s_overflow), 64'd0);
    end
    idle();
    check("lag_overflow", 64'(s_overflow), 64'd1);
    check("lag_err", 64'(s_err), 64'd1);
    check("lag_halted", 64'(s_halted), 64'd0);

    // Wdata mismatch on record 5
    do_clear();
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 32'(4 * i), 1'b1, 5'(i), (i == 5) ? 32'h55 : 32'(i));
      set_b(1'b1, 32'(4 * i), 1'b1, 5'(i), (i == 5) ? 32'h56 : 32'(i));
      tick();
      if (i == 5) check("wd_err_early", 64'(s_err), 64'd0);
      if (i == 6) begin
        check("wd_err", 64'(s_err), 64'd1);
        check("wd_halted", 64'(s_halted), 64'd1);
      end
    end
    idle();
    tick();
    tick();
    check("wd_fail_a_pc", 64'(s_fail_a_pc), 64'h14);
    check("wd_fail_b_pc", 64'(s_fail_b_pc), 64'h14);
    check("wd_fail_a_wdata", 64'(s_fail_a_wdata), 64'h55);
    check("wd_fail_b_wdata", 64'(s_fail_b_wdata), 64'h56);
    check("wd_fail_rd", 64'(s_fail_rd), 64'd5);
    check("wd_cmp_frozen", 64'(s_cmp_count), 64'd6);
    check("wd_mis", 64'(s_mis_count), 64'd1);
    check("wd_ns_cmp", 64'(n_cmp_count), 64'd10);
    check("wd_ns_mis", 64'(n_mis_count), 64'd1);
    check("wd_ns_halted", 64'(n_halted), 64'd0);

    // x0 write on A versus no write on B
    do_clear();
    check("clr_halted", 64'(s_halted), 64'd0);
    set_a(1'b1, 32'h100, 1'b1, 5'd0, 32'h1234);
    set_b(1'b1, 32'h100, 1'b0, 5'd7, 32'h99);
    tick();
    idle();
    tick();
    check("x0_err", 64'(s_err), 64'd0);
    check("x0_cmp", 64'(s_cmp_count), 64'd1);

    // Three PC mismatches with STOP_ON_ERR=0
    do_clear();
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 32'(4 * i), 1'b1, 5'(i), 32'(i + 256));
      set_b(1'b1, (i == 2 || i == 4 || i == 7) ? 32'(4 * i + 4096) : 32'(4 * i),
            1'b1, 5'(i), 32'(i + 256));
      tick();
    end
    idle();
    tick();
    check("pc_ns_mis", 64'(n_mis_count), 64'd3);
    check("pc_ns_cmp", 64'(n_cmp_count), 64'd10);
    check("pc_ns_err", 64'(n_err), 64'd1);
    check("pc_ns_halted", 64'(n_halted), 64'd0);
    check("pc_ns_fail_a_pc", 64'(n_fail_a_pc), 64'h8);
    check("pc_ns_fail_b_pc", 64'(n_fail_b_pc), 64'h1008);
    check("pc_ns_fail_rd", 64'(n_fail_rd), 64'd2);
    check("pc_ns_fail_wdata", 64'(n_fail_a_wdata), 64'h102);

    // Clear mid-stream, with an A-only record presented in the clear cycle
    for (int i = 0; i < 3; i++) begin
      set_a(1'b1, 32'(4 * i), 1'b1, 5'(i), 32'(i));
      set_b(1'b1, 32'(4 * i + 4096), 1'b1, 5'(i), 32'(i));
      tick();
    end
    clear = 1'b1;
    set_a(1'b1, 32'h500, 1'b1, 5'd3, 32'h77);
    set_b(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    clear = 1'b0;
    idle();
    check("mid_clr_err", 64'(n_err), 64'd0);
    check("mid_clr_mis", 64'(n_mis_count), 64'd0);
    check("mid_clr_cmp", 64'(n_cmp_count), 64'd0);
    check("mid_clr_fail_pc", 64'(n_fail_a_pc), 64'd0);
    check("mid_clr_overflow", 64'(n_overflow), 64'd0);
    check("mid_clr_s_halted", 64'(s_halted), 64'd0);
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 32'(4 * i + 64), 1'b1, 5'(i + 1), 32'(i * 3));
      set_b(1'b1, 32'(4 * i + 64), 1'b1, 5'(i + 1), 32'(i * 3));
      tick();
    end
    idle();
    tick();
    check("post_clr_ns_err", 64'(n_err), 64'd0);
    check("post_clr_ns_cmp", 64'(n_cmp_count), 64'd5);
    check("post_clr_s_err", 64'(s_err), 64'd0);
    check("post_clr_s_cmp", 64'(s_cmp_count), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
